// File: rtl/axi_test_sequencer_if.sv
// Control/status bundle between the test sequencer, its host and the
// AXI master test engine it drives.
interface axi_test_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_runs;
    logic             init_axi_txn;
    logic             txn_done;
    logic             txn_error;
    logic             busy;
    logic             seq_done;
    logic             all_pass;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] timeout_cnt;
    logic             aborted;

    modport master (
        input  start, abort, num_runs, txn_done, txn_error,
        output init_axi_txn, busy, seq_done, all_pass,
        output pass_cnt, fail_cnt, timeout_cnt, aborted
    );

    modport slave (
        output start, abort, num_runs, txn_done, txn_error,
        input  init_axi_txn, busy, seq_done, all_pass,
        input  pass_cnt, fail_cnt, timeout_cnt, aborted
    );
endinterface

// File: rtl/axi_test_sequencer.sv
// Runs the AXI master test engine num_runs times, pulsing init and
// tallying pass / fail / timeout results from its done/error levels.
module axi_test_sequencer #(
    parameter int CNT_W             = 8,
    parameter int INIT_PULSE_CYCLES = 2,
    parameter int GAP_CYCLES        = 4,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input logic                  ACLK,
    input logic                  ARESETN,
    axi_test_sequencer_if.master bus
);
    localparam int M1 = (INIT_PULSE_CYCLES > GAP_CYCLES) ?
                        INIT_PULSE_CYCLES : GAP_CYCLES;
    localparam int MC = (M1 > TIMEOUT_CYCLES) ? M1 : TIMEOUT_CYCLES;
    localparam int TW = $clog2(MC + 1);

    localparam logic [TW-1:0] P_LAST = TW'(INIT_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] G_LAST =
        TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, PULSE, WAIT_DONE, GAP, FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0] runs_q, runs_d;
    logic [CNT_W-1:0] nrun_q, nrun_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic [CNT_W-1:0] to_q, to_d;
    logic             done_q;
    logic             init_q, init_d;
    logic             busy_q, busy_d;
    logic             sdone_q, sdone_d;
    logic             apass_q, apass_d;
    logic             abt_q, abt_d;
    logic             done_edge;
    logic             last_run;

    assign done_edge = bus.txn_done & ~done_q;
    assign last_run  = (runs_q + CNT_W'(1)) == nrun_q;

    // Next state and next value of every registered output.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + TW'(1);
        runs_d  = runs_q;
        nrun_d  = nrun_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        to_d    = to_q;
        init_d  = init_q;
        busy_d  = busy_q;
        sdone_d = sdone_q;
        apass_d = apass_q;
        abt_d   = abt_q;
        unique case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (bus.start && !bus.abort) begin
                    nrun_d  = bus.num_runs;
                    runs_d  = '0;
                    pass_d  = '0;
                    fail_d  = '0;
                    to_d    = '0;
                    apass_d = 1'b0;
                    abt_d   = 1'b0;
                    busy_d  = 1'b1;
                    if (bus.num_runs == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = PULSE;
                        init_d  = 1'b1;
                    end
                end
            end
            PULSE: begin
                if (tmr_q == P_LAST) begin
                    state_d = WAIT_DONE;
                    init_d  = 1'b0;
                    tmr_d   = '0;
                end
            end
            WAIT_DONE: begin
                if (done_edge || tmr_q == T_LAST) begin
                    if (!done_edge) begin
                        fail_d = fail_q + CNT_W'(1);
                        to_d   = to_q + CNT_W'(1);
                    end else if (bus.txn_error) begin
                        fail_d = fail_q + CNT_W'(1);
                    end else begin
                        pass_d = pass_q + CNT_W'(1);
                    end
                    runs_d = runs_q + CNT_W'(1);
                    tmr_d  = '0;
                    if (last_run) begin
                        state_d = FINISH;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = PULSE;
                        init_d  = 1'b1;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (tmr_q == G_LAST) begin
                    state_d = PULSE;
                    init_d  = 1'b1;
                    tmr_d   = '0;
                end
            end
            FINISH: begin
                if (!sdone_q) begin
                    sdone_d = 1'b1;
                    apass_d = (fail_q == '0);
                end else begin
                    state_d = IDLE;
                    sdone_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            tmr_d   = '0;
            runs_d  = runs_q;
            pass_d  = pass_q;
            fail_d  = fail_q;
            to_d    = to_q;
            init_d  = 1'b0;
            busy_d  = 1'b0;
            sdone_d = 1'b0;
            apass_d = 1'b0;
            abt_d   = 1'b1;
        end
    end

    // State, counters, done history and registered outputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            runs_q  <= '0;
            nrun_q  <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            to_q    <= '0;
            done_q  <= 1'b0;
            init_q  <= 1'b0;
            busy_q  <= 1'b0;
            sdone_q <= 1'b0;
            apass_q <= 1'b0;
            abt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            runs_q  <= runs_d;
            nrun_q  <= nrun_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            to_q    <= to_d;
            done_q  <= bus.txn_done;
            init_q  <= init_d;
            busy_q  <= busy_d;
            sdone_q <= sdone_d;
            apass_q <= apass_d;
            abt_q   <= abt_d;
        end
    end

    assign bus.init_axi_txn = init_q;
    assign bus.busy         = busy_q;
    assign bus.seq_done     = sdone_q;
    assign bus.all_pass     = apass_q;
    assign bus.pass_cnt     = pass_q;
    assign bus.fail_cnt     = fail_q;
    assign bus.timeout_cnt  = to_q;
    assign bus.aborted      = abt_q;
endmodule

// File: doc/axi_test_sequencer.md
AXI_TEST_SEQUENCER -- requirements
Module: axi_test_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of run count and result counters.
REQ-002 SHALL have parameter INIT_PULSE_CYCLES, default 2, number of cycles init_axi_txn is held high per run (minimum 1).
REQ-003 SHALL have parameter GAP_CYCLES, default 4, number of idle cycles between the end of one run and the next init pulse (0 allowed).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, number of WAIT_DONE cycles before a run is declared timed out.
REQ-005 ACLK  input  1  sole clock; all state changes on the rising edge.
REQ-006 ARESETN  input  1  reset, asynchronous assert, active-low.
REQ-007 start  input  1  request a sequence; sampled only in IDLE.
REQ-008 abort  input  1  cancel the sequence in progress.
REQ-009 num_runs  input  CNT_W  number of runs; latched on an accepted start.
REQ-010 init_axi_txn  output  1  init pulse to the AXI master test engine.
REQ-011 txn_done  input  1  done level from the engine.
REQ-012 txn_error  input  1  error level from the engine, valid with txn_done.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 seq_done  output  1  one-cycle pulse at sequence completion.
REQ-015 all_pass  output  1  high after completion when fail_cnt is zero.
REQ-016 pass_cnt, fail_cnt, timeout_cnt  output  CNT_W each  result counters.
REQ-017 aborted  output  1  sticky; set by abort, cleared by the next accepted start.

Function
REQ-018 SHALL implement states IDLE, PULSE, WAIT_DONE, GAP, FINISH; all outputs SHALL be registered.
REQ-019 IDLE with start=1 at edge k SHALL: latch num_runs; clear pass_cnt, fail_cnt, timeout_cnt, all_pass and aborted; set busy. If num_runs=0 go to FINISH, else go to PULSE with init_axi_txn=1 from edge k.
REQ-020 PULSE SHALL hold init_axi_txn=1 for exactly INIT_PULSE_CYCLES cycles, then enter WAIT_DONE with init_axi_txn=0.
REQ-021 SHALL register txn_done every cycle in all states; a done edge is txn_done=1 while the registered value is 0.
REQ-022 Done edges outside WAIT_DONE SHALL be ignored.
REQ-023 In WAIT_DONE, a done edge SHALL increment fail_cnt if txn_error=1 in the same cycle, otherwise increment pass_cnt.
REQ-024 In WAIT_DONE, a timer SHALL start at 0 on entry; when it reaches TIMEOUT_CYCLES-1 with no done edge, fail_cnt and timeout_cnt SHALL increment.
REQ-025 A done edge in the same cycle as timer expiry SHALL count as done (REQ-023), not as a timeout.
REQ-026 After a run is counted, the sequencer SHALL go to FINISH if completed runs equal num_runs; otherwise it SHALL go to GAP, or directly to PULSE if GAP_CYCLES=0.
REQ-027 GAP SHALL last exactly GAP_CYCLES cycles and then enter PULSE.
REQ-028 FINISH SHALL assert seq_done for one cycle, set all_pass=(fail_cnt==0), and return to IDLE with busy=0 on the next edge.
REQ-029 all_pass and all counters SHALL hold their values in IDLE until the next accepted start.
REQ-030 Counters cannot exceed num_runs, so no overflow handling SHALL be required; internal arithmetic SHALL be CNT_W-bit unsigned.
REQ-031 abort=1 in any non-IDLE state SHALL, at the next edge: enter IDLE; drive init_axi_txn=0 and busy=0; set aborted=1; hold all counters; suppress seq_done; leave all_pass=0.
REQ-032 abort SHALL have priority over every other transition; abort in IDLE SHALL have no effect, including when start=1 in the same cycle.
REQ-033 start while busy SHALL be ignored.

Reset
REQ-034 While ARESETN=0, the state SHALL be IDLE and every output and counter SHALL be 0, asynchronously.
REQ-035 Reset asserted mid-sequence SHALL discard the sequence; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-036 num_runs=3, engine responds with a done edge 10 cycles after each init, txn_error=0 -> three init pulses of 2 cycles each, spaced as specified; pass_cnt=3, fail_cnt=0, seq_done pulses once, all_pass=1.
REQ-037 num_runs=4, txn_error=1 on run 2 only -> pass_cnt=3, fail_cnt=1, timeout_cnt=0, all_pass=0.
REQ-038 TIMEOUT_CYCLES=16, engine never responds, num_runs=2 -> each WAIT_DONE lasts exactly 16 cycles; timeout_cnt=2, fail_cnt=2, seq_done=1.
REQ-039 num_runs=0 -> busy for 2 cycles, no init pulse, seq_done=1, all_pass=1.
REQ-040 abort during the second WAIT_DONE of 5 runs -> next edge: IDLE, aborted=1, pass_cnt=1, no seq_done; a following start clears aborted and runs normally.
REQ-041 ARESETN low during PULSE -> init_axi_txn drops asynchronously; a txn_done already high at release produces no count.
